trng_keygen_ctrl: RTL
=====================

// Module: trng_keygen_ctrl
// PURPOSE
//  Next-gen TRNG post-processing core: takes the raw bit stream of the ring-oscillator entropy source,
//  runs NIST SP800-90B online health tests (RCT + APT) per bit, assembles KEY_W-bit keys, buffers
//  FIFO_DEPTH keys with ready/valid output, and raises a level-threshold/failure interrupt.
//  Sits between top_level_RO and the bus slave; replaces the single-register key path.
// PARAMETERS
//  KEY_W         32   key width in bits (>=8)
//  FIFO_DEPTH    4    keys buffered (power of 2, >=2)
//  RCT_CUTOFF    32   repetition-count cutoff: run of identical raw bits that flags failure
//  APT_WINDOW    512  adaptive-proportion window, raw bits (power of 2)
//  APT_CUTOFF    410  count of the window's first bit value that flags failure (< APT_WINDOW)
//  FAIL_THRESH   11   consecutive failed words that trigger total failure
//  STARTUP_WORDS 2    health-tested words discarded after enable
// PORTS
//  clk             in   1                 clock
//  rst_n           in   1                 async active-low reset
//  enable_i        in   1                 block enable; low = flush and IDLE
//  clear_i         in   1                 pulse: leave FAILED
//  rnd_bit_i       in   1                 raw entropy bit
//  rnd_valid_i     in   1                 rnd_bit_i valid this cycle
//  sample_en_o     out  1                 sampling enable to entropy source (its dff_en)
//  key_o           out  KEY_W             FIFO head key; all-zero when key_valid_o=0
//  key_valid_o     out  1                 FIFO not empty
//  key_ready_i     in   1                 consumer pop; pop on valid&&ready
//  fifo_level_o    out  $clog2(DEPTH)+1   keys stored
//  intr_level_i    in   $clog2(DEPTH)+1   interrupt threshold; 0 disables level interrupt
//  error_o         out  1                 registered 1-cycle pulse per discarded (failed) word
//  total_failure_o out  1                 state==FAILED
//  trng_intr_o     out  1                 registered: (intr_level_i!=0 && level>=intr_level_i) || FAILED
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, all counters/shift reg 0.
//  FSM: IDLE -(enable_i)-> STARTUP -(STARTUP_WORDS good words)-> COLLECT;
//   STARTUP: any failed word -> FAILED. COLLECT: fail_cnt==FAIL_THRESH -> FAILED.
//   FAILED -(clear_i && enable_i)-> STARTUP. enable_i low in any state -> IDLE next cycle.
//  sample_en_o = enable_i && state in {STARTUP,COLLECT} && !fifo_full (combinational).
//  Bit accepted when rnd_valid_i && sample_en_o; else ignored. Accepted bit shifts in at LSB.
//  RCT: run counter on accepted raw bits; reaching RCT_CUTOFF sets word fail flag, run restarts at 1.
//  APT: first bit of window is reference; count matches incl. first; reaching APT_CUTOFF sets fail flag;
//   window wraps after APT_WINDOW bits with new reference. Tests persist across words.
//  Word complete on KEY_W-th accepted bit: fail flag set -> discard, error_o pulse, fail_cnt++;
//   else STARTUP: discard, startup_cnt++; COLLECT: push, fail_cnt=0. Fail flag/bit count clear.
//  Push visible at key_valid_o next cycle. Push & pop same cycle: level unchanged.
//  Pop on empty ignored; FIFO never full at push (sample_en_o gate).
//  Popped entry zeroed. enable_i low or entering FAILED: FIFO, shift reg, partial word flushed
//   next cycle; health counters reset on IDLE only.
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: von Neumann stage after health tests: accepted raw bits paired;
//   01->0, 10->1, 00/11 dropped; word completes on KEY_W debiased bits. Health tests see raw bits.
//  Undefined: every accepted raw bit goes to the key shift register.
// STRUCTURE
//  trng_pkg: state enum (IDLE,STARTUP,COLLECT,FAILED), width localparam helpers.
//  Sub-module trng_key_fifo (param width/depth, push/pop, level, zero-on-pop, sync flush).
//  Health tests, debias and FSM inline in trng_keygen_ctrl.
// TESTING
//  Alternating 0101.. bits, KEY_W=32: 2 words dropped, 3rd key_o=32'h55555555, level 1.
//  Constant 1 stream in COLLECT: word fails every 32 bits; FAILED after 11th, intr and total_failure=1.
//  Fill FIFO (4 keys), key_ready_i=0: sample_en_o=0, extra rnd_valid_i ignored; pop -> sampling resumes.
//  intr_level_i=3: intr rises cycle after level hits 3; simultaneous push/pop at level 3 holds intr.
//  enable_i drop mid-word with 2 keys stored: next cycle level=0, key_o=0, state IDLE.
//  VN_DEBIAS_EN: pairs 10,01,11,00 x16 -> bits 1,0 only; key_o=32'hAAAAAAAA after startup.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and width helpers for the TRNG key generation controller.
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STARTUP = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FAILED  = 2'd3
    } trng_state_e;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/trng_key_fifo.sv
// Key buffer: power-of-two depth FIFO with level output, zero-on-pop and synchronous flush.
module trng_key_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;
    assign level   = count;

    // NOTE: the storage array is reset and flushed explicitly so stale key material never lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            // Written after the zeroing so a full-FIFO push/pop on the same slot keeps the new key.
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trng_keygen_ctrl.sv
// TRNG post-processing: RCT/APT health tests, key assembly, key FIFO and interrupt.
// Optional von Neumann debiasing is enabled by defining TRNG_VN_DEBIAS_EN.
module trng_keygen_ctrl
    import trng_pkg::*;
#(
    parameter int KEY_W         = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int RCT_CUTOFF    = 32,
    parameter int APT_WINDOW    = 512,
    parameter int APT_CUTOFF    = 410,
    parameter int FAIL_THRESH   = 11,
    parameter int STARTUP_WORDS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    input  logic                          clear_i,
    input  logic                          rnd_bit_i,
    input  logic                          rnd_valid_i,
    output logic                          sample_en_o,
    output logic [KEY_W-1:0]              key_o,
    output logic                          key_valid_o,
    input  logic                          key_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    input  logic [$clog2(FIFO_DEPTH):0]   intr_level_i,
    output logic                          error_o,
    output logic                          total_failure_o,
    output logic                          trng_intr_o
);
    localparam int BW  = cnt_w(KEY_W);
    localparam int RW  = cnt_w(RCT_CUTOFF);
    localparam int AW  = $clog2(APT_WINDOW);
    localparam int ACW = cnt_w(APT_WINDOW);
    localparam int FW  = cnt_w(FAIL_THRESH);
    localparam int SW  = cnt_w(STARTUP_WORDS);

    trng_state_e state, next_state;

    logic             fifo_full;
    logic             accept;
    logic             flush;
    logic             push;
    logic [RW-1:0]    rct_cnt, rct_next;
    logic             rct_last, rct_hit;
    logic [AW-1:0]    apt_idx;
    logic [ACW-1:0]   apt_cnt, apt_next;
    logic             apt_ref, apt_first, apt_hit;
    logic             data_valid, data_bit;
    logic [KEY_W-1:0] shift;
    logic [BW-1:0]    bit_cnt;
    logic             word_fail, word_done, word_bad;
    logic [FW-1:0]    fail_cnt;
    logic [SW-1:0]    startup_cnt;

    assign sample_en_o = enable_i && (state == ST_STARTUP || state == ST_COLLECT) && !fifo_full;
    assign accept      = rnd_valid_i && sample_en_o;

    assign rct_next  = (rct_cnt != '0 && rnd_bit_i == rct_last) ? rct_cnt + 1'b1 : RW'(1);
    assign rct_hit   = accept && (rct_next == RW'(RCT_CUTOFF));
    assign apt_first = (apt_idx == '0);
    assign apt_next  = apt_first ? ACW'(1) : apt_cnt + ACW'(rnd_bit_i == apt_ref);
    assign apt_hit   = accept && (apt_next == ACW'(APT_CUTOFF));

`ifdef TRNG_VN_DEBIAS_EN
    logic vn_have, vn_first;

    // Pairs 01/10 yield their first bit; 00/11 are dropped.
    assign data_valid = accept && vn_have && (vn_first != rnd_bit_i);
    assign data_bit   = vn_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (flush) begin
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (accept) begin
            vn_have <= !vn_have;
            if (!vn_have) vn_first <= rnd_bit_i;
        end
    end
`else
    assign data_valid = accept;
    assign data_bit   = rnd_bit_i;
`endif

    assign word_done = data_valid && (bit_cnt == BW'(KEY_W - 1));
    assign word_bad  = word_fail || rct_hit || apt_hit;
    assign flush     = (next_state == ST_IDLE) || (next_state == ST_FAILED);
    assign push      = word_done && !word_bad && (state == ST_COLLECT) && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        if (!enable_i) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    next_state = ST_STARTUP;
                ST_STARTUP: if (word_done) begin
                    if (word_bad)                                 next_state = ST_FAILED;
                    else if (startup_cnt == SW'(STARTUP_WORDS - 1)) next_state = ST_COLLECT;
                end
                ST_COLLECT: if (fail_cnt == FW'(FAIL_THRESH)) next_state = ST_FAILED;
                ST_FAILED:  if (clear_i) next_state = ST_STARTUP;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Health tests run continuously across words and restart only from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rct_cnt  <= '0;
            rct_last <= 1'b0;
            apt_idx  <= '0;
            apt_cnt  <= '0;
            apt_ref  <= 1'b0;
        end else if (state == ST_IDLE) begin
            rct_cnt  <= '0;
            rct_last <= 1'b0;
            apt_idx  <= '0;
            apt_cnt  <= '0;
            apt_ref  <= 1'b0;
        end else if (accept) begin
            rct_last <= rnd_bit_i;
            rct_cnt  <= rct_hit ? RW'(1) : rct_next;
            apt_idx  <= apt_idx + 1'b1;
            apt_cnt  <= apt_next;
            if (apt_first) apt_ref <= rnd_bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_cnt   <= '0;
            word_fail <= 1'b0;
        end else if (flush) begin
            shift     <= '0;
            bit_cnt   <= '0;
            word_fail <= 1'b0;
        end else begin
            if (word_done)              word_fail <= 1'b0;
            else if (rct_hit || apt_hit) word_fail <= 1'b1;
            if (data_valid) begin
                shift   <= {shift[KEY_W-2:0], data_bit};
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt    <= '0;
            startup_cnt <= '0;
        end else begin
            if (state != ST_STARTUP) startup_cnt <= '0;
            if (state == ST_IDLE || state == ST_FAILED) begin
                fail_cnt <= '0;
            end else if (word_done && !flush) begin
                if (word_bad) begin
                    if (fail_cnt != FW'(FAIL_THRESH)) fail_cnt <= fail_cnt + 1'b1;
                end else if (state == ST_STARTUP) begin
                    startup_cnt <= startup_cnt + 1'b1;
                end else begin
                    fail_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_o     <= 1'b0;
            trng_intr_o <= 1'b0;
        end else begin
            error_o     <= word_done && word_bad;
            trng_intr_o <= ((intr_level_i != '0) && (fifo_level_o >= intr_level_i))
                           || (state == ST_FAILED);
        end
    end

    assign total_failure_o = (state == ST_FAILED);

    trng_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata ({shift[KEY_W-2:0], data_bit}),
        .pop   (key_ready_i),
        .rdata (key_o),
        .valid (key_valid_o),
        .full  (fifo_full),
        .level (fifo_level_o)
    );

endmodule
